// File: rtl/popcnt_pkg.sv
`default_nettype none
// ==================================================================
// popcnt_pkg : shared encodings and helpers for the popcount engine
// Rev 1.0
// ==================================================================
package popcnt_pkg;

  localparam logic [1:0] POPCNT_ONES    = 2'd0;
  localparam logic [1:0] POPCNT_ZEROS   = 2'd1;
  localparam logic [1:0] POPCNT_HAMMING = 2'd2;
  localparam logic [1:0] POPCNT_MASKED  = 2'd3;

  typedef enum logic [2:0] {
    ST_RESET   = 3'd0,
    ST_IDLE    = 3'd1,
    ST_WORKING = 3'd2,
    ST_DRAIN   = 3'd3,
    ST_DONE    = 3'd4
  } state_e;

  // Bits needed to hold a per-word count of 0..data_w.
  function automatic int unsigned cnt_width(input int unsigned data_w);
    return $clog2(data_w) + 1;
  endfunction

  // Number of valid LSBs in the final word; a tail of 0 means the whole word.
  function automatic int unsigned tail_mask_width(input int unsigned tail,
                                                  input int unsigned data_w);
    return (tail == 0) ? data_w : tail;
  endfunction

endpackage
`default_nettype wire

// File: rtl/popcnt_tree.sv
`default_nettype none
// ==================================================================
// popcnt_tree : combinational popcount, nibble lookup + log2 adder tree
// Rev 1.0
// ==================================================================
module popcnt_tree
  import popcnt_pkg::*;
#(
  parameter int unsigned DATA_W   = 64,
  parameter int unsigned CNT_BITS = cnt_width(DATA_W)
) (
  input  logic [DATA_W-1:0]   data,
  output logic [CNT_BITS-1:0] count
);

  localparam int unsigned NIB  = DATA_W / 4;
  localparam int unsigned LVLS = $clog2(NIB);

  function automatic logic [2:0] nib_pop(input logic [3:0] n);
    case (n)
      4'h0:                         return 3'd0;
      4'h1, 4'h2, 4'h4, 4'h8:       return 3'd1;
      4'h7, 4'hB, 4'hD, 4'hE:       return 3'd3;
      4'hF:                         return 3'd4;
      default:                      return 3'd2;
    endcase
  endfunction

  for (genvar l = 0; l <= LVLS; l++) begin : g_lvl
    logic [CNT_BITS-1:0] s [NIB >> l];
    if (l == 0) begin : g_leaf
      for (genvar i = 0; i < NIB; i++) begin : g_nib
        assign s[i] = {{(CNT_BITS-3){1'b0}}, nib_pop(data[4*i +: 4])};
      end
    end else begin : g_add
      for (genvar i = 0; i < (NIB >> l); i++) begin : g_pair
        assign s[i] = g_lvl[l-1].s[2*i] + g_lvl[l-1].s[2*i+1];
      end
    end
  end

  assign count = g_lvl[LVLS].s[0];

endmodule
`default_nettype wire

// File: rtl/popcnt_engine.sv
`default_nettype none
// ==================================================================
// popcnt_engine : streaming job-based saturating population counter
// Rev 1.0
// ==================================================================
module popcnt_engine
  import popcnt_pkg::*;
#(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned LEN_W  = 32,
  parameter int unsigned CNT_W  = 64,
  parameter int unsigned TAIL_W = $clog2(DATA_W)
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              start_rdy,
  input  logic              start_vld,
  input  logic [LEN_W-1:0]  start_len,
  input  logic [1:0]        start_mode,
  input  logic [DATA_W-1:0] start_key,
  input  logic [TAIL_W-1:0] start_tail,
  input  logic              ivld,
  input  logic [DATA_W-1:0] idat,
  output logic              irdy,
  input  logic              done_full,
  output logic              done_wr,
  output logic [CNT_W-1:0]  done_count
);

  localparam int unsigned CNT_BITS = cnt_width(DATA_W);

  state_e              state_q, state_d;
  logic [LEN_W-1:0]    left_q, left_d;
  logic [1:0]          mode_q, mode_d;
  logic [DATA_W-1:0]   key_q, key_d;
  logic [TAIL_W-1:0]   tail_q, tail_d;
  logic                s1_vld_q, s1_vld_d;
  logic [DATA_W-1:0]   s1_dat_q, s1_dat_d;
  logic                s2_vld_q, s2_vld_d;
  logic [CNT_BITS-1:0] s2_cnt_q, s2_cnt_d;
  logic [CNT_W-1:0]    acc_q, acc_d;

  logic                start_fire;
  logic                accept;
  logic                last_word;
  logic [DATA_W-1:0]   tail_mask;
  logic [DATA_W-1:0]   xform;
  logic [CNT_BITS-1:0] tree_cnt;
  logic [CNT_W:0]      sum;

  assign start_rdy  = (state_q == ST_IDLE);
  assign irdy       = (state_q == ST_WORKING);
  assign done_wr    = (state_q == ST_DONE) && !done_full;
  assign done_count = acc_q;

  assign start_fire = start_vld && start_rdy;
  assign accept     = ivld && irdy;
  assign last_word  = (left_q == LEN_W'(1));

  always_comb begin
    tail_mask = '0;
    for (int unsigned i = 0; i < DATA_W; i++) begin
      tail_mask[i] = (i < tail_mask_width(32'(tail_q), DATA_W));
    end
  end

  always_comb begin
    xform = idat;
    case (mode_q)
      POPCNT_ONES:    xform = idat;
      POPCNT_ZEROS:   xform = ~idat;
      POPCNT_HAMMING: xform = idat ^ key_q;
      default:        xform = idat & key_q;
    endcase
    // Masking after the transform keeps dropped bits out of every mode.
    if (last_word && (tail_q != '0)) begin
      xform = xform & tail_mask;
    end
  end

  popcnt_tree #(.DATA_W(DATA_W)) u_tree (
    .data  (s1_dat_q),
    .count (tree_cnt)
  );

  assign sum = {1'b0, acc_q} + (CNT_W+1)'(s2_cnt_q);

  always_comb begin
    state_d  = state_q;
    left_d   = left_q;
    mode_d   = mode_q;
    key_d    = key_q;
    tail_d   = tail_q;
    s1_vld_d = accept;
    s1_dat_d = accept ? xform : s1_dat_q;
    s2_vld_d = s1_vld_q;
    s2_cnt_d = tree_cnt;
    acc_d    = acc_q;

    if (s2_vld_q) begin
      acc_d = sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
    end

    case (state_q)
      ST_RESET: state_d = ST_IDLE;
      ST_IDLE: begin
        if (start_fire) begin
          left_d  = start_len;
          mode_d  = start_mode;
          key_d   = start_key;
          tail_d  = start_tail;
          acc_d   = '0;
          state_d = (start_len == '0) ? ST_DONE : ST_WORKING;
        end
      end
      ST_WORKING: begin
        if (accept) begin
          left_d = left_q - LEN_W'(1);
          if (last_word) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (!s1_vld_q && !s2_vld_q) state_d = ST_DONE;
      end
      ST_DONE: begin
        if (done_wr) state_d = ST_IDLE;
      end
      default: state_d = ST_RESET;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_RESET;
      left_q   <= '0;
      s1_vld_q <= 1'b0;
      s2_vld_q <= 1'b0;
      acc_q    <= '0;
    end else begin
      state_q  <= state_d;
      left_q   <= left_d;
      s1_vld_q <= s1_vld_d;
      s2_vld_q <= s2_vld_d;
      acc_q    <= acc_d;
    end
  end

  // Data-path registers are qualified by the valids and need no reset.
  always_ff @(posedge clk) begin
    mode_q   <= mode_d;
    key_q    <= key_d;
    tail_q   <= tail_d;
    s1_dat_q <= s1_dat_d;
    s2_cnt_q <= s2_cnt_d;
  end

endmodule
`default_nettype wire

// File: tb/tb_popcnt_engine.sv
`default_nettype none
// ==================================================================
// tb_popcnt_engine : table-driven and randomized bench for popcnt_engine
// Rev 1.0
// ==================================================================
module tb_popcnt_engine;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_vld = 1'b0;
  logic [31:0] start_len = '0;
  logic [1:0]  start_mode = '0;
  logic [63:0] start_key = '0;
  logic [5:0]  start_tail = '0;
  logic        ivld = 1'b0;
  logic [63:0] idat = '0;
  logic        done_full = 1'b0;

  logic        start_rdy, irdy, done_wr;
  logic [63:0] done_count;
  logic        start_rdy8, irdy8, done_wr8;
  logic [7:0]  done_count8;

  always #5 clk = ~clk;

  popcnt_engine #(.DATA_W(64), .LEN_W(32), .CNT_W(64), .TAIL_W(6)) dut (
    .clk(clk), .rst_n(rst_n), .start_rdy(start_rdy), .start_vld(start_vld),
    .start_len(start_len), .start_mode(start_mode), .start_key(start_key),
    .start_tail(start_tail), .ivld(ivld), .idat(idat), .irdy(irdy),
    .done_full(done_full), .done_wr(done_wr), .done_count(done_count)
  );

  popcnt_engine #(.DATA_W(64), .LEN_W(32), .CNT_W(8), .TAIL_W(6)) dut8 (
    .clk(clk), .rst_n(rst_n), .start_rdy(start_rdy8), .start_vld(start_vld),
    .start_len(start_len), .start_mode(start_mode), .start_key(start_key),
    .start_tail(start_tail), .ivld(ivld), .idat(idat), .irdy(irdy8),
    .done_full(done_full), .done_wr(done_wr8), .done_count(done_count8)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [63:0] jw[$];

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          len;
    int          md;
    logic [63:0] key;
    int          tl;
    logic [63:0] w [6];
    logic [63:0] e64;
    logic [63:0] e8;
  } vec_t;

  vec_t tbl [7];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: sum of per-word popcounts after transform and tail masking, clamped.
  function automatic logic [63:0] model(input int len, input int md, input logic [63:0] key,
                                        input int tl, input int cw);
    logic [63:0] sum, x, one, lim;
    sum = 0;
    one = 64'd1;
    for (int i = 0; i < len; i++) begin
      case (md)
        0:       x = jw[i];
        1:       x = ~jw[i];
        2:       x = jw[i] ^ key;
        default: x = jw[i] & key;
      endcase
      if (i == len - 1 && tl != 0) x = x & ((one << tl) - one);
      sum = sum + 64'($countones(x));
    end
    if (cw < 64) begin
      lim = (one << cw) - one;
      if (sum > lim) sum = lim;
    end
    return sum;
  endfunction

  task automatic do_job(input int len, input int md, input logic [63:0] key, input int tl,
                        input bit gaps, input int hold, input string tag,
                        output logic [63:0] c64, output logic [63:0] c8);
    int n, sc, la, i, base;
    bit irdy_seen, wr_early, unstable;
    logic [63:0] held;
    c64 = '1;
    c8 = '1;
    n = 0;
    while (!start_rdy && n < 50) begin step(); n++; end
    if (!start_rdy) begin
      check({tag, " start_rdy_timeout"}, 64'(start_rdy), 64'd1);
      return;
    end
    done_full  = (hold > 0);
    start_vld  = 1'b1;
    start_len  = 32'(len);
    start_mode = 2'(md);
    start_key  = key;
    start_tail = 6'(tl);
    sc = cyc;
    step();
    start_vld = 1'b0;
    la = sc;
    i = 0;
    n = 0;
    irdy_seen = 0;
    while (i < len && n < 500) begin
      ivld = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      idat = jw[i];
      if (irdy) irdy_seen = 1;
      if (ivld && irdy) begin la = cyc; i++; end
      step();
      n++;
    end
    ivld = 1'b0;
    if (i < len) check({tag, " accept_timeout"}, 64'(i), 64'(len));
    base = (len == 0) ? 1 : 4;
    if (hold > 0) begin
      wr_early = 0;
      unstable = 0;
      while (cyc < la + base) begin
        if (done_wr) wr_early = 1;
        step();
      end
      held = done_count;
      while (cyc < la + base + hold) begin
        if (done_wr) wr_early = 1;
        if (done_count !== held) unstable = 1;
        step();
      end
      check({tag, " wr_while_full"}, 64'(wr_early), 64'd0);
      check({tag, " count_stable_full"}, 64'(unstable), 64'd0);
      done_full = 1'b0;
      #1;
    end
    n = 0;
    while (!done_wr && n < 60) begin
      if (irdy) irdy_seen = 1;
      step();
      n++;
    end
    check({tag, " latency"}, 64'(cyc - la), 64'(base + hold));
    if (len == 0) check({tag, " irdy_on_empty"}, 64'(irdy_seen), 64'd0);
    check({tag, " wr8_aligned"}, 64'(done_wr8), 64'd1);
    c64 = done_count;
    c8  = 64'(done_count8);
    step();
    check({tag, " single_pulse"}, 64'(done_wr), 64'd0);
    check({tag, " rdy_after"}, 64'(start_rdy), 64'd1);
    check({tag, " count_held"}, done_count, c64);
  endtask

  task automatic set_vec(input int k, input int len, input int md, input logic [63:0] key,
                         input int tl, input logic [63:0] w0, input logic [63:0] w1,
                         input logic [63:0] w2, input logic [63:0] w3, input logic [63:0] w4,
                         input logic [63:0] e64, input logic [63:0] e8);
    tbl[k].len = len; tbl[k].md = md; tbl[k].key = key; tbl[k].tl = tl;
    tbl[k].w[0] = w0; tbl[k].w[1] = w1; tbl[k].w[2] = w2;
    tbl[k].w[3] = w3; tbl[k].w[4] = w4; tbl[k].w[5] = 64'd0;
    tbl[k].e64 = e64; tbl[k].e8 = e8;
  endtask

  initial begin
    logic [63:0] c64, c8, e64, e8;
    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
    int len, md, tl, hold, n;
    logic [63:0] key;
    bit wr_seen;

    set_vec(0, 3, 0, 64'h0,  0, ONES, 64'h0, 64'h1, 64'h0, 64'h0, 64'd65, 64'd65);
    set_vec(1, 2, 1, 64'h0,  4, 64'h0, 64'h0, 64'h0, 64'h0, 64'h0, 64'd68, 64'd68);
    set_vec(2, 1, 2, 64'hFF, 0, 64'h0F, 64'h0, 64'h0, 64'h0, 64'h0, 64'd4, 64'd4);
    set_vec(3, 0, 3, 64'h0,  0, 64'h0, 64'h0, 64'h0, 64'h0, 64'h0, 64'd0, 64'd0);
    set_vec(4, 5, 0, 64'h0,  0, ONES, ONES, ONES, ONES, ONES, 64'd320, 64'd255);
    set_vec(5, 2, 3, 64'hF0F0_F0F0_F0F0_F0F0, 8, ONES, ONES, 64'h0, 64'h0, 64'h0,
            64'd36, 64'd36);
    set_vec(6, 3, 2, 64'h0, 1, 64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555, 64'h3,
            64'h0, 64'h0, 64'd65, 64'd65);

    rst_n = 1'b0;
    repeat (3) step();
    check("reset start_rdy", 64'(start_rdy), 64'd0);
    check("reset irdy", 64'(irdy), 64'd0);
    check("reset done_wr", 64'(done_wr), 64'd0);
    check("reset done_count", done_count, 64'd0);
    rst_n = 1'b1;
    check("release start_rdy_c1", 64'(start_rdy), 64'd0);
    step();
    check("release start_rdy_c2", 64'(start_rdy), 64'd1);

    for (int k = 0; k < 7; k++) begin
      jw = {};
      for (int j = 0; j < tbl[k].len; j++) jw.push_back(tbl[k].w[j]);
      do_job(tbl[k].len, tbl[k].md, tbl[k].key, tbl[k].tl, 1'b0, 0, $sformatf("vec%0d", k),
             c64, c8);
      check($sformatf("vec%0d count64", k), c64, tbl[k].e64);
      check($sformatf("vec%0d count8", k), c8, tbl[k].e8);
    end

    // Done FIFO back-pressure for 10 cycles.
    jw = {};
    jw.push_back(64'h0000_0000_0000_FFFF);
    jw.push_back(64'h0000_0000_0000_00FF);
    do_job(2, 0, 64'h0, 0, 1'b0, 10, "full_hold", c64, c8);
    check("full_hold count64", c64, 64'd24);

    // Reset in the middle of a 6-word job discards it.
    n = 0;
    while (!start_rdy && n < 50) begin step(); n++; end
    start_vld = 1'b1; start_len = 32'd6; start_mode = 2'd0; start_tail = 6'd0;
    step();
    start_vld = 1'b0;
    n = 0;
    for (int j = 0; j < 2 && n < 20; ) begin
      ivld = 1'b1;
      idat = ONES;
      if (irdy) j++;
      step();
      n++;
    end
    ivld = 1'b0;
    rst_n = 1'b0;
    wr_seen = 0;
    repeat (2) begin step(); if (done_wr) wr_seen = 1; end
    check("midrst irdy", 64'(irdy), 64'd0);
    check("midrst count", done_count, 64'd0);
    rst_n = 1'b1;
    repeat (4) begin if (done_wr) wr_seen = 1; step(); end
    check("midrst no_done_wr", 64'(wr_seen), 64'd0);
    jw = {};
    jw.push_back(64'h3);
    do_job(1, 0, 64'h0, 0, 1'b0, 0, "post_rst", c64, c8);
    check("post_rst count64", c64, 64'd2);

    for (int r = 0; r < 30; r++) begin
      len  = $urandom_range(0, 10);
      md   = $urandom_range(0, 3);
      key  = {$urandom, $urandom};
      tl   = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 63);
      hold = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 5) : 0;
      jw = {};
      for (int j = 0; j < len; j++)
        jw.push_back(((r % 4) == 0) ? ONES : {$urandom, $urandom});
      e64 = model(len, md, key, tl, 64);
      e8  = model(len, md, key, tl, 8);
      do_job(len, md, key, tl, 1'b1, hold, $sformatf("rnd%0d", r), c64, c8);
      check($sformatf("rnd%0d count64", r), c64, e64);
      check($sformatf("rnd%0d count8", r), c8, e8);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
